// File: rtl/ctrl_reg_mp_if.sv
// ctrl_reg_mp_if: write-port and status bundle between write sources (master) and ctrl_reg_mp (slave)
interface ctrl_reg_mp_if #(
  parameter int N = 32,
  parameter int NUM_WR = 2,
  parameter int CNT_W = 8
);
  logic [NUM_WR-1:0] wr_i;
  logic [NUM_WR*N-1:0] data_i;
  logic [NUM_WR*N/8-1:0] be_i;
  logic hw_clr_i;
  logic clr_coll_i;
  logic [N-1:0] control_o;
  logic start_pulse_o;
  logic busy_o;
  logic collision_o;
  logic [CNT_W-1:0] coll_cnt_o;
  modport master (
    output wr_i, data_i, be_i, hw_clr_i, clr_coll_i,
    input control_o, start_pulse_o, busy_o, collision_o, coll_cnt_o
  );
  modport slave (
    input wr_i, data_i, be_i, hw_clr_i, clr_coll_i,
    output control_o, start_pulse_o, busy_o, collision_o, coll_cnt_o
  );
endinterface

// File: rtl/ctrl_reg_mp.sv
// ctrl_reg_mp: prioritised byte-enabled control register with start-pulse FSM and saturating collision counter
module ctrl_reg_mp #(
  parameter int N = 32,
  parameter int NUM_WR = 2,
  parameter int START_BIT = 0,
  parameter int CNT_W = 8
) (
  input logic clk_i,
  input logic rst_n_i,
  ctrl_reg_mp_if.slave bus
);
  localparam int NB = N / 8;
  typedef enum logic [1:0] {IDLE, PULSE, BUSY} state_t;
  state_t state, state_nx;
  logic [N-1:0] win_data, ctrl_q, ctrl_nx;
  logic [NB-1:0] win_be;
  logic [CNT_W-1:0] cnt_q;
  logic coll_q, eff, coll;
  always_comb begin
    win_data = '0;
    win_be = '0;
    for (int j = NUM_WR - 1; j >= 0; j--)
      if (bus.wr_i[j]) begin
        win_data = bus.data_i[j*N +: N];
        win_be = bus.be_i[j*NB +: NB];
      end
  end
  assign eff = win_be[START_BIT/8];
  assign coll = |(bus.wr_i & (bus.wr_i - NUM_WR'(1)));
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)
      ? ((eff && win_data[START_BIT] && !bus.hw_clr_i) ? PULSE : IDLE)
      : ((bus.hw_clr_i || (eff && !win_data[START_BIT])) ? IDLE : BUSY);
  end
  always_comb begin
    ctrl_nx = ctrl_q;
    for (int b = 0; b < NB; b++)
      ctrl_nx[b*8 +: 8] = win_be[b] ? win_data[b*8 +: 8] : ctrl_q[b*8 +: 8];
    ctrl_nx[START_BIT] = (state_nx != IDLE);
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      ctrl_q <= '0;
      coll_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      ctrl_q <= ctrl_nx;
      coll_q <= !bus.clr_coll_i && (coll || coll_q);
      cnt_q <= bus.clr_coll_i ? '0 : (coll && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end
  assign bus.control_o = ctrl_q;
  assign bus.start_pulse_o = (state == PULSE);
  assign bus.busy_o = (state != IDLE);
  assign bus.collision_o = coll_q;
  assign bus.coll_cnt_o = cnt_q;
endmodule
